dm_port_arbiter: RTL and testbench

Two-requester arbiter and command sequencer in front of the data memory. The CPU MEM-stage port (requester 0) and a DMA/debug loader port (requester 1) share the single memory port. The block grants one request per cycle and registers the winning command. It then drives the memory's store-enable, access type, address and write data for exactly one cycle and returns a response to the owner. Misaligned accesses are rejected without touching memory.

---
 rtl/dm_port_arbiter_pkg.sv | 34 +++
 rtl/dm_port_arbiter_if.sv | 37 +++
 rtl/dm_align_check.sv | 22 ++
 rtl/dm_port_arbiter.sv | 112 +++++++++++
 tb/tb_dm_port_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter and its
// alignment checker.
package dm_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned N_REQ  = 2;

    typedef enum logic [1:0] {
        TYPE_ILL  = 2'b00,
        TYPE_BYTE = 2'b01,
        TYPE_HALF = 2'b10,
        TYPE_WORD = 2'b11
    } acc_type_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef struct packed {
        logic              we;
        acc_type_e         atype;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [PC_W-1:0]   pc;
        logic              err;
    } dm_cmd_t;

    // Requester index to one-hot request/response vector.
    function automatic logic [N_REQ-1:0] req_onehot(input logic idx);
        return (idx == REQ_DMA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the
// data memory. The arbiter uses the slave modport.
interface dm_port_arbiter_if;
    import dm_port_arbiter_pkg::*;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_we;
    logic [2*N_REQ-1:0]      req_type;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ*PC_W-1:0]   req_pc;

    logic [N_REQ-1:0]        resp_valid;
    logic                    resp_err;
    logic [DATA_W-1:0]       resp_rdata;

    logic                    dm_scr;
    logic [1:0]              dm_type;
    logic [ADDR_W-1:0]       dm_addr;
    logic [DATA_W-1:0]       dm_din;
    logic [PC_W-1:0]         dm_pc;
    logic [DATA_W-1:0]       dm_dout;

    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata, req_pc, dm_dout,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  dm_scr, dm_type, dm_addr, dm_din, dm_pc
    );

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata, req_pc, dm_dout,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output dm_scr, dm_type, dm_addr, dm_din, dm_pc
    );

endinterface

// File: rtl/dm_align_check.sv
// Combinational legality check of an access type against the low address
// bits; shared with the CPU exception logic.
module dm_align_check
    import dm_port_arbiter_pkg::*;
(
    input  acc_type_e  atype_i,
    input  logic [1:0] addr_lo_i,
    output logic       err_c_o
);

    always_comb begin
        err_c_o = 1'b0;
        case (atype_i)
            TYPE_ILL:  err_c_o = 1'b1;
            TYPE_BYTE: err_c_o = 1'b0;
            TYPE_HALF: err_c_o = addr_lo_i[0];
            TYPE_WORD: err_c_o = |addr_lo_i;
            default:   err_c_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// CPU/DMA arbiter and one-cycle command sequencer for the data-memory port.
// Define DM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed CPU priority.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    dm_port_arbiter_if.slave   bus_io
);

    logic             req_any_c;
    logic             win_c;
    logic [N_REQ-1:0] grant_c;

    acc_type_e         sel_type_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic              sel_err_c;
    dm_cmd_t           cmd_d;

    dm_cmd_t cmd_q;
    logic    owner_q;
    logic    cmd_valid_q;
    logic    active_c;

`ifdef DM_ARB_ROUND_ROBIN_EN
    logic prio_q;
    logic prio_d;

    // Contended grants go to the pointer and hand priority to the loser.
    always_comb begin
        prio_d = prio_q;
        win_c  = REQ_CPU;
        if (&bus_io.req_valid) begin
            win_c  = prio_q;
            prio_d = ~prio_q;
        end else if (bus_io.req_valid[REQ_DMA]) begin
            win_c = REQ_DMA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= REQ_CPU;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    always_comb begin
        win_c = bus_io.req_valid[REQ_CPU] ? REQ_CPU : REQ_DMA;
    end
`endif

    assign req_any_c        = (|bus_io.req_valid) & ~reset;
    assign grant_c          = req_any_c ? req_onehot(win_c) : '0;
    assign bus_io.req_ready = grant_c;

    // Mux the winning requester's fields into the next command.
    always_comb begin
        if (win_c == REQ_DMA) begin
            sel_type_c  = acc_type_e'(bus_io.req_type[3:2]);
            sel_addr_c  = bus_io.req_addr[2*ADDR_W-1:ADDR_W];
            cmd_d.we    = bus_io.req_we[REQ_DMA];
            cmd_d.wdata = bus_io.req_wdata[2*DATA_W-1:DATA_W];
            cmd_d.pc    = bus_io.req_pc[2*PC_W-1:PC_W];
        end else begin
            sel_type_c  = acc_type_e'(bus_io.req_type[1:0]);
            sel_addr_c  = bus_io.req_addr[ADDR_W-1:0];
            cmd_d.we    = bus_io.req_we[REQ_CPU];
            cmd_d.wdata = bus_io.req_wdata[DATA_W-1:0];
            cmd_d.pc    = bus_io.req_pc[PC_W-1:0];
        end
        cmd_d.atype = sel_type_c;
        cmd_d.addr  = sel_addr_c;
        cmd_d.err   = sel_err_c;
    end

    dm_align_check u_align (
        .atype_i   (sel_type_c),
        .addr_lo_i (sel_addr_c[1:0]),
        .err_c_o   (sel_err_c)
    );

    // Command register; fields hold while idle so the memory bus stays quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q       <= '0;
            owner_q     <= REQ_CPU;
            cmd_valid_q <= 1'b0;
        end else begin
            cmd_valid_q <= req_any_c;
            if (req_any_c) begin
                cmd_q   <= cmd_d;
                owner_q <= win_c;
            end
        end
    end

    // Reset in the execute cycle squashes both the store and the response.
    assign active_c = cmd_valid_q & ~reset;

    assign bus_io.dm_scr     = active_c & cmd_q.we & ~cmd_q.err;
    assign bus_io.dm_type    = active_c ? cmd_q.atype : TYPE_ILL;
    assign bus_io.dm_addr    = cmd_q.addr;
    assign bus_io.dm_din     = cmd_q.wdata;
    assign bus_io.dm_pc      = cmd_q.pc;

    assign bus_io.resp_valid = active_c ? req_onehot(owner_q) : '0;
    assign bus_io.resp_err   = active_c & cmd_q.err;
    assign bus_io.resp_rdata = bus_io.dm_dout;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter with a byte-lane data memory model.
module tb_dm_port_arbiter;
    import dm_port_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dm_port_arbiter_if bus ();

    dm_port_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    // Memory: word i preloaded with 0x11110000 + i.
    logic [31:0] mem [64];
    logic        seeded = 1'b0;
    assign bus.dm_dout = mem[bus.dm_addr[7:2]];

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1111_0000 + 32'(i);
            seeded <= 1'b1;
        end else if (bus.dm_scr) begin
            case (bus.dm_type)
                2'b01: mem[bus.dm_addr[7:2]][{bus.dm_addr[1:0], 3'b000} +: 8]  <= bus.dm_din[7:0];
                2'b10: mem[bus.dm_addr[7:2]][{bus.dm_addr[1], 4'b0000} +: 16] <= bus.dm_din[15:0];
                2'b11: mem[bus.dm_addr[7:2]] <= bus.dm_din;
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        owner;
        logic        err;
        logic        scr;
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] pc;
        logic        chk_rd;
        logic [31:0] rd;
        logic        follow;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   last_cyc = -10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_req();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_type  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_pc    = '0;
    endtask

    task automatic set_req(input int idx, input logic we, input logic [1:0] typ,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] pc);
        bus.req_we[idx]             = we;
        bus.req_type[idx*2 +: 2]    = typ;
        bus.req_addr[idx*32 +: 32]  = addr;
        bus.req_wdata[idx*32 +: 32] = wdata;
        bus.req_pc[idx*32 +: 32]    = pc;
        bus.req_valid[idx]          = 1'b1;
    endtask

    // One requester alone for one cycle; checks the grant and queues the response.
    task automatic send(input string name, input int idx, input logic we,
                        input logic [1:0] typ, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] pc,
                        input logic exp_err, input logic chk_rd,
                        input logic [31:0] rd, input logic follow, input logic push);
        exp_t e;
        @(negedge clk);
        clear_req();
        set_req(idx, we, typ, addr, wdata, pc);
        #1;
        chk({name, " ready"}, 32'(bus.req_ready), (idx == 1) ? 32'd2 : 32'd1);
        e.owner  = (idx == 1);
        e.err    = exp_err;
        e.scr    = we & ~exp_err;
        e.typ    = typ;
        e.addr   = addr;
        e.din    = wdata;
        e.pc     = pc;
        e.chk_rd = chk_rd;
        e.rd     = rd;
        e.follow = follow;
        if (push) sb_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        clear_req();
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (bus.resp_valid != 2'b00) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_resp: got resp_valid=%b with nothing outstanding", bus.resp_valid);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_valid", 32'(bus.resp_valid), e.owner ? 32'd2 : 32'd1);
                    chk("resp_err",   32'(bus.resp_err),   32'(e.err));
                    chk("dm_scr",     32'(bus.dm_scr),     32'(e.scr));
                    chk("dm_type",    32'(bus.dm_type),    32'(e.typ));
                    chk("dm_addr",    bus.dm_addr,         e.addr);
                    chk("dm_din",     bus.dm_din,          e.din);
                    chk("dm_pc",      bus.dm_pc,           e.pc);
                    if (e.chk_rd) chk("resp_rdata", bus.resp_rdata, e.rd);
                    if (e.follow) chk("no_bubble", 32'(cyc), 32'(last_cyc + 1));
                end
                last_cyc = cyc;
            end
        end
    end

    initial begin
        logic [1:0] exp_gnt;
        exp_t       e;

        clear_req();
        set_req(0, 1'b1, 2'b11, 32'h4, 32'h5, 32'h6);
        set_req(1, 1'b1, 2'b11, 32'h8, 32'h9, 32'hA);
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready",  32'(bus.req_ready),  32'd0);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst resp_err",   32'(bus.resp_err),   32'd0);
        chk("rst dm_scr",     32'(bus.dm_scr),     32'd0);
        chk("rst dm_type",    32'(bus.dm_type),    32'd0);
        chk("rst dm_addr",    bus.dm_addr,         32'd0);
        chk("rst dm_din",     bus.dm_din,          32'd0);
        chk("rst dm_pc",      bus.dm_pc,           32'd0);
        chk("rst resp_rdata", bus.resp_rdata,      32'h1111_0000);
        @(negedge clk);
        clear_req();
        reset = 1'b0;

        // CPU store word, then DMA load of the same word.
        send("cpu_sw",  0, 1'b1, 2'b11, 32'h10, 32'hDEADBEEF, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle();
        send("dma_lw",  1, 1'b0, 2'b11, 32'h10, 32'h0, 32'h200, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        idle();

        // Both requesters loading for four cycles.
        @(negedge clk);
        clear_req();
        set_req(0, 1'b0, 2'b11, 32'h10, 32'h0, 32'h104);
        set_req(1, 1'b0, 2'b11, 32'h10, 32'h0, 32'h204);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
`ifdef DM_ARB_ROUND_ROBIN_EN
            exp_gnt = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_gnt = 2'b01;
`endif
            chk("contend ready", 32'(bus.req_ready), 32'(exp_gnt));
            e.owner  = exp_gnt[1];
            e.err    = 1'b0;
            e.scr    = 1'b0;
            e.typ    = 2'b11;
            e.addr   = 32'h10;
            e.din    = 32'h0;
            e.pc     = exp_gnt[1] ? 32'h204 : 32'h104;
            e.chk_rd = 1'b1;
            e.rd     = 32'hDEADBEEF;
            e.follow = (i > 0);
            sb_q.push_back(e);
        end
        idle();

        // Misaligned half store is rejected; the word stays at its preload.
        send("cpu_sh_mis", 0, 1'b1, 2'b10, 32'h21, 32'h1234, 32'h108, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        idle();
        send("cpu_lw20",   0, 1'b0, 2'b11, 32'h20, 32'h0, 32'h10C, 1'b0, 1'b1, 32'h1111_0008, 1'b0, 1'b1);
        idle();
        send("cpu_ill",    0, 1'b0, 2'b00, 32'h20, 32'h0, 32'h110, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        send("dma_lw_mis", 1, 1'b0, 2'b11, 32'h22, 32'h0, 32'h210, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        send("dma_sh_ok",  1, 1'b1, 2'b10, 32'h26, 32'h0000BEEF, 32'h214, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        send("dma_lw24",   1, 1'b0, 2'b11, 32'h24, 32'h0, 32'h218, 1'b0, 1'b1, 32'hBEEF_0009, 1'b1, 1'b1);
        idle();

        // Byte store immediately followed by a word load of the same word.
        send("cpu_sb",   0, 1'b1, 2'b01, 32'h31, 32'h0000_00AB, 32'h120, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        send("cpu_lw30", 0, 1'b0, 2'b11, 32'h30, 32'h0, 32'h124, 1'b0, 1'b1, 32'h1111_AB0C, 1'b1, 1'b1);
        idle();

        // Reset in the execute cycle of an accepted DMA store.
        send("dma_sw_rst", 1, 1'b1, 2'b11, 32'h40, 32'hCAFEF00D, 32'h220, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_req();
        #1;
        chk("rst_squash dm_scr",     32'(bus.dm_scr),     32'd0);
        chk("rst_squash resp_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send("dma_lw40", 1, 1'b0, 2'b11, 32'h40, 32'h0, 32'h224, 1'b0, 1'b1, 32'h1111_0010, 1'b0, 1'b1);
        idle();

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
